// File: rtl/per2rate_if.sv
// ---------------------------------------------------------------------------
// per2rate_if : period-in / rate-out handshake bundle for per2rate
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface per2rate_if #(
    parameter int PER_W  = 19,
    parameter int RATE_W = 8
);
    logic [PER_W-1:0]  per_i;
    logic              per_valid_i;
    logic              per_ready_o;
    logic              avg_en_i;
    logic              clr_i;
    logic [RATE_W-1:0] rate_o;
    logic              sat_o;
    logic              rate_valid_o;
    logic              rate_ready_i;

    modport slave (
        input  per_i, per_valid_i, avg_en_i, clr_i, rate_ready_i,
        output per_ready_o, rate_o, sat_o, rate_valid_o
    );

    modport master (
        output per_i, per_valid_i, avg_en_i, clr_i, rate_ready_i,
        input  per_ready_o, rate_o, sat_o, rate_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/per2rate.sv
// ---------------------------------------------------------------------------
// per2rate : converts a measured period into a saturated rate DIVIDEND/period,
//            optionally over a running average of the last 2^AVG_LOG2 periods
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module per2rate #(
    parameter int DIVIDEND = 292968,
    parameter int PER_W    = 19,
    parameter int RATE_MAX = 250,
    parameter int AVG_LOG2 = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    per2rate_if.slave   bus
);
    localparam int DIV_W     = $clog2(DIVIDEND + 1);
    localparam int RATE_W    = $clog2(RATE_MAX + 1);
    localparam int c_n       = 1 << AVG_LOG2;
    localparam int c_sum_w   = PER_W + AVG_LOG2;
    localparam int c_ptr_w   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int c_cnt_w   = AVG_LOG2 + 1;
    localparam int c_step_w  = (DIV_W > 1) ? $clog2(DIV_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state, w_state_next;
    logic   w_per_ready, w_rate_valid, w_accept, w_last;

    logic [PER_W-1:0]   r_hist [c_n];
    logic [c_sum_w-1:0] r_sum;
    logic [c_ptr_w-1:0] r_ptr;
    logic [c_cnt_w-1:0] r_fill;

    logic [PER_W-1:0]   w_old;
    logic [c_ptr_w-1:0] w_wr_ptr, w_ptr_next;
    logic [c_sum_w-1:0] w_sum_next;
    logic [c_cnt_w-1:0] w_fill_base, w_fill_next;

    logic [PER_W-1:0]    r_per, r_avg_div, r_divisor, r_rem, w_rem_next;
    logic                r_avg_en, r_full;
    logic [DIV_W-1:0]    r_num, r_quo, w_quo_next;
    logic [c_step_w-1:0] r_step;
    logic [PER_W:0]      w_trial;
    logic                w_ge;
    logic [RATE_W-1:0]   r_rate;
    logic                r_sat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_per_ready  = 1'b0;
        w_rate_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_per_ready = ~rst_i;
                if (w_accept) w_state_next = S_LOAD;
            end
            S_LOAD: w_state_next = S_DIV;
            S_DIV:  if (w_last) w_state_next = S_DONE;
            S_DONE: begin
                w_rate_valid = 1'b1;
                if (bus.rate_ready_i) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_accept = bus.per_valid_i & w_per_ready;
    assign w_last   = (r_step == c_step_w'(DIV_W - 1));

    // A clear coincident with an accept empties the history before the new write
    assign w_old       = bus.clr_i ? '0 : r_hist[r_ptr];
    assign w_wr_ptr    = bus.clr_i ? '0 : r_ptr;
    assign w_ptr_next  = (w_wr_ptr == c_ptr_w'(c_n - 1)) ? '0 : w_wr_ptr + c_ptr_w'(1);
    assign w_sum_next  = (bus.clr_i ? '0 : r_sum) - c_sum_w'(w_old) + c_sum_w'(bus.per_i);
    assign w_fill_base = bus.clr_i ? '0 : r_fill;
    assign w_fill_next = (w_fill_base == c_cnt_w'(c_n)) ? w_fill_base
                                                         : w_fill_base + c_cnt_w'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_n; i++) r_hist[i] <= '0;
            r_sum  <= '0;
            r_ptr  <= '0;
            r_fill <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < c_n; i++) if (bus.clr_i) r_hist[i] <= '0;
            r_hist[w_wr_ptr] <= bus.per_i;
            r_sum  <= w_sum_next;
            r_ptr  <= w_ptr_next;
            r_fill <= w_fill_next;
        end else if (bus.clr_i) begin
            for (int i = 0; i < c_n; i++) r_hist[i] <= '0;
            r_sum  <= '0;
            r_ptr  <= '0;
            r_fill <= '0;
        end
    end

    assign w_trial    = {r_rem, r_num[DIV_W-1]};
    assign w_ge       = (w_trial >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? PER_W'(w_trial - {1'b0, r_divisor}) : PER_W'(w_trial);
    assign w_quo_next = DIV_W'({r_quo, w_ge});

    // Average candidate is captured at accept so a later clear cannot alter this job
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_per     <= '0;
            r_avg_en  <= 1'b0;
            r_avg_div <= '0;
            r_full    <= 1'b0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_num     <= '0;
            r_quo     <= '0;
            r_step    <= '0;
            r_rate    <= '0;
            r_sat     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_per     <= bus.per_i;
                    r_avg_en  <= bus.avg_en_i;
                    r_avg_div <= PER_W'(w_sum_next >> AVG_LOG2);
                    r_full    <= (w_fill_next == c_cnt_w'(c_n));
                end
                S_LOAD: begin
                    r_divisor <= (r_avg_en & r_full) ? r_avg_div : r_per;
                    r_rem     <= '0;
                    r_num     <= DIV_W'(DIVIDEND);
                    r_quo     <= '0;
                    r_step    <= '0;
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_num  <= r_num << 1;
                    r_quo  <= w_quo_next;
                    r_step <= r_step + c_step_w'(1);
                    if (w_last) begin
                        if ((r_divisor == '0) || (w_quo_next > DIV_W'(RATE_MAX))) begin
                            r_rate <= RATE_W'(RATE_MAX);
                            r_sat  <= 1'b1;
                        end else begin
                            r_rate <= RATE_W'(w_quo_next);
                            r_sat  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.per_ready_o  = w_per_ready;
    assign bus.rate_valid_o = w_rate_valid;
    assign bus.rate_o       = r_rate;
    assign bus.sat_o        = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_per2rate.sv
// ---------------------------------------------------------------------------
// tb_per2rate : directed and randomized checks of per2rate against a queue model
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_per2rate;
    localparam int DIVIDEND = 292968;
    localparam int PER_W    = 19;
    localparam int RATE_MAX = 250;
    localparam int AVG_LOG2 = 2;
    localparam int N        = 1 << AVG_LOG2;
    localparam int DIV_W    = $clog2(DIVIDEND + 1);
    localparam int RATE_W   = $clog2(RATE_MAX + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    per2rate_if #(.PER_W(PER_W), .RATE_W(RATE_W)) bus ();

    per2rate #(
        .DIVIDEND(DIVIDEND), .PER_W(PER_W), .RATE_MAX(RATE_MAX), .AVG_LOG2(AVG_LOG2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned hist_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // History of the last N accepted periods; divisor chosen from that history
    function automatic int unsigned model_accept(input int unsigned per, input bit avg, input bit clr);
        longint unsigned s = 0;
        if (clr) hist_q.delete();
        hist_q.push_back(per);
        if (hist_q.size() > N) void'(hist_q.pop_front());
        if (avg && hist_q.size() == N) begin
            foreach (hist_q[i]) s += hist_q[i];
            return int'(s / N);
        end
        return per;
    endfunction

    function automatic void model_rate(input int unsigned dv, output int unsigned rate, output bit sat);
        int unsigned q;
        if (dv == 0) begin
            rate = RATE_MAX; sat = 1'b1;
        end else begin
            q = DIVIDEND / dv;
            if (q > RATE_MAX) begin rate = RATE_MAX; sat = 1'b1; end
            else              begin rate = q;        sat = 1'b0; end
        end
    endfunction

    task automatic run_txn(input int unsigned per, input bit avg, input bit clr,
                           input int hold, input bit mid_clr, output int unsigned got);
        int unsigned dv, exp_rate;
        bit          exp_sat;
        int          lat;
        chk("ready_in_idle", bus.per_ready_o, 1);
        bus.per_i       = PER_W'(per);
        bus.avg_en_i    = avg;
        bus.clr_i       = clr;
        bus.per_valid_i = 1'b1;
        cyc();
        bus.per_valid_i = 1'b0;
        bus.clr_i       = 1'b0;
        dv = model_accept(per, avg, clr);
        model_rate(dv, exp_rate, exp_sat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 4) begin
                bus.per_valid_i = 1'b1;
                bus.per_i       = PER_W'($urandom);
            end
            if (mid_clr && k == 6) bus.clr_i = 1'b1;
            cyc();
            bus.per_valid_i = 1'b0;
            bus.clr_i       = 1'b0;
            if (bus.rate_valid_o === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (mid_clr) hist_q.delete();
        chk("latency", lat, DIV_W + 1);
        chk("rate", bus.rate_o, exp_rate);
        chk("sat", bus.sat_o, exp_sat);
        chk("ready_busy", bus.per_ready_o, 0);
        got = bus.rate_o;
        for (int h = 0; h < hold; h++) begin
            bus.rate_ready_i = 1'b0;
            bus.per_valid_i  = 1'b1;
            bus.per_i        = PER_W'($urandom_range(1, 5000));
            cyc();
            chk("hold_valid", bus.rate_valid_o, 1);
            chk("hold_rate", bus.rate_o, exp_rate);
            chk("hold_ready", bus.per_ready_o, 0);
        end
        bus.per_valid_i  = 1'b0;
        bus.rate_ready_i = 1'b1;
        cyc();
        bus.rate_ready_i = 1'b0;
        chk("valid_drop", bus.rate_valid_o, 0);
        chk("rate_kept", bus.rate_o, exp_rate);
    endtask

    initial begin
        int unsigned got, per;
        bit          seen;
        int          sel;

        rst              = 1'b1;
        bus.per_i        = '0;
        bus.per_valid_i  = 1'b0;
        bus.avg_en_i     = 1'b0;
        bus.clr_i        = 1'b0;
        bus.rate_ready_i = 1'b0;
        cyc(); cyc();
        chk("rst_rate", bus.rate_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        chk("rst_valid", bus.rate_valid_o, 0);
        chk("rst_ready", bus.per_ready_o, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.per_ready_o, 1);

        run_txn(2930, 0, 0, 0, 0, got); chk("p2930", got, 99);
        run_txn(1000, 0, 0, 0, 0, got); chk("p1000", got, 250);
        chk("p1000_sat", bus.sat_o, 1);
        run_txn(0,    0, 0, 1, 0, got); chk("p0", got, 250);
        chk("p0_sat", bus.sat_o, 1);
        run_txn(1171, 0, 0, 0, 0, got); chk("p1171", got, 250);
        chk("p1171_sat", bus.sat_o, 0);

        run_txn(2000, 1, 1, 0, 0, got); chk("avg1", got, 146);
        run_txn(2000, 1, 0, 0, 0, got); chk("avg2", got, 146);
        run_txn(2000, 1, 0, 0, 0, got); chk("avg3", got, 146);
        run_txn(2400, 1, 0, 5, 0, got); chk("avg4", got, 139);

        run_txn(3000, 1, 1, 0, 0, got); chk("clr_accept", got, 97);
        run_txn(2000, 1, 0, 0, 0, got); chk("fill2", got, 146);
        run_txn(2000, 1, 0, 0, 0, got);
        run_txn(2000, 1, 0, 0, 0, got); chk("fill4_avg", got, 130);

        // Abort a division with reset and confirm no result surfaces
        bus.per_i = PER_W'(2930); bus.avg_en_i = 1'b0; bus.per_valid_i = 1'b1;
        cyc();
        bus.per_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_rate", bus.rate_o, 0);
        chk("mid_rst_sat", bus.sat_o, 0);
        chk("mid_rst_valid", bus.rate_valid_o, 0);
        chk("mid_rst_ready", bus.per_ready_o, 0);
        hist_q.delete();
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.per_ready_o, 1);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (bus.rate_valid_o !== 1'b0) seen = 1'b1;
        end
        chk("aborted_no_result", seen, 0);
        run_txn(2930, 0, 0, 0, 0, got); chk("post_rst_p2930", got, 99);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0:       per = 0;
                1:       per = $urandom_range(0, (1 << PER_W) - 1);
                2, 3:    per = $urandom_range(1, 1200);
                default: per = $urandom_range(1100, 6000);
            endcase
            run_txn(per, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3), ($urandom_range(0, 7) == 0), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire

// File: doc/per2rate.md
PER2RATE -- requirements
Module: per2rate

Interface
REQ-001 SHALL have parameter DIVIDEND, default 292968, meaning the constant numerator (ticks·rate per minute).
REQ-002 SHALL have parameter PER_W, default 19, meaning the period input width.
REQ-003 SHALL have parameter RATE_MAX, default 250, meaning the saturation ceiling of the result.
REQ-004 SHALL have parameter AVG_LOG2, default 2, legal 0..3, meaning history depth N = 2^AVG_LOG2.
REQ-005 SHALL derive DIV_W = clog2(DIVIDEND+1) and RATE_W = clog2(RATE_MAX+1), both not overridable.
REQ-006 clk_i  in  1  clock; all logic on the rising edge.
REQ-007 rst_i  in  1  reset, asynchronous, active-high.
REQ-008 per_i  in  PER_W  measured period in ticks.
REQ-009 per_valid_i  in  1  per_i valid.
REQ-010 per_ready_o  out  1  block can accept a period.
REQ-011 avg_en_i  in  1  mode: 1 = averaged period, 0 = latest period; sampled at accept.
REQ-012 clr_i  in  1  synchronous clear of the period history.
REQ-013 rate_o  out  RATE_W  computed rate, registered.
REQ-014 sat_o  out  1  rate_o was clamped; qualified by rate_valid_o.
REQ-015 rate_valid_o  out  1  result valid.
REQ-016 rate_ready_i  in  1  consumer accepts the result.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD -> DIV -> DONE -> IDLE and no other reachable encoding.
REQ-018 per_ready_o SHALL be 1 exactly in IDLE with rst_i low; accept = per_valid_i & per_ready_o.
REQ-019 IDLE->LOAD on accept; per_i, avg_en_i latched on that edge.
REQ-020 On accept, per_i SHALL be written to a circular history of N entries; the running sum (PER_W+AVG_LOG2 bits) SHALL add per_i and subtract the overwritten entry; the fill count saturates at N.
REQ-021 LOAD SHALL select the divisor: sum >> AVG_LOG2 (floor) if latched avg_en = 1 and history is full, otherwise the latched per_i; LOAD lasts 1 cycle.
REQ-022 DIV SHALL run a restoring divide, one quotient bit per cycle MSB-first, for exactly DIV_W cycles, then go to DONE.
REQ-023 Divisor 0 SHALL skip the arithmetic result and yield rate_o = RATE_MAX, sat_o = 1.
REQ-024 Quotient q = floor(DIVIDEND/divisor) at full DIV_W width; q > RATE_MAX SHALL give rate_o = RATE_MAX, sat_o = 1; else rate_o = q, sat_o = 0.
REQ-025 rate_o and sat_o SHALL be updated on the DIV->DONE edge and held stable until the next DIV->DONE edge.
REQ-026 rate_valid_o SHALL be 1 exactly in DONE; DONE->IDLE when rate_ready_i = 1; otherwise DONE holds indefinitely.
REQ-027 Latency: rate_valid_o SHALL first be 1 in the cycle following the (DIV_W+1)th rising edge after the accepting edge.
REQ-028 clr_i SHALL zero history entries, the sum and the fill count, in any state, without disturbing an in-flight division.
REQ-029 clr_i coincident with accept: the clear applies first, then the new sample is written; fill count = 1.
REQ-030 per_valid_i outside IDLE SHALL be ignored; no buffering.

Reset
REQ-031 rst_i high SHALL force IDLE, rate_o = 0, sat_o = 0, rate_valid_o = 0, per_ready_o = 0, history/sum/count = 0, from any state, including mid-DIV.
REQ-032 After rst_i deasserts, per_ready_o SHALL be 1 in the first cycle; an aborted division produces no result.

Verification
REQ-033 Defaults, avg_en = 0, per_i = 2930 -> rate_o = 99, sat_o = 0, rate_valid_o 20 edges after accept.
REQ-034 per_i = 1000 -> rate_o = 250, sat_o = 1; per_i = 0 -> rate_o = 250, sat_o = 1; per_i = 1171 -> rate_o = 250, sat_o = 0.
REQ-035 avg_en = 1, periods 2000, 2000, 2000, 2400 -> rate_o = 146, 146, 146, 139 (4th uses average 2100).
REQ-036 Hold rate_ready_i low 5 cycles in DONE -> rate_valid_o, rate_o stable, per_ready_o = 0, per_valid_i ignored.
REQ-037 clr_i with accept of 3000 after full history, avg_en = 1 -> latest-period path, rate_o = 97; fill count = 1.
REQ-038 rst_i pulse mid-DIV -> all outputs 0 immediately, no rate_valid_o; the next accept computes correctly.
